mem_port_arbiter: RTL and testbench

//  Shares one single-ported, variable-latency backing memory between the rv32i

---
 rtl/mem_port_arbiter_if.sv | 48 ++++
 rtl/mem_port_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch/load-store request ports and shared memory port bundle
interface mem_port_arbiter_if #(
  parameter int XLEN = 32
);
  logic            i_req;
  logic [XLEN-1:0] i_addr;
  logic            i_done;
  logic [XLEN-1:0] i_rdata;
  logic            i_fault;

  logic            d_req;
  logic            d_write_en;
  logic [XLEN-1:0] d_addr;
  logic [XLEN-1:0] d_wdata;
  logic [1:0]      d_width;
  logic            d_done;
  logic [XLEN-1:0] d_rdata;
  logic            d_fault;

  logic            mem_req;
  logic            mem_write_en;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [1:0]      mem_width;
  logic            mem_ack;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_fault;

  // Arbiter side
  modport slave (
    input  i_req, i_addr,
    input  d_req, d_write_en, d_addr, d_wdata, d_width,
    input  mem_ack, mem_rdata, mem_fault,
    output i_done, i_rdata, i_fault,
    output d_done, d_rdata, d_fault,
    output mem_req, mem_write_en, mem_addr, mem_wdata, mem_width
  );

  // Pipeline and memory side
  modport master (
    output i_req, i_addr,
    output d_req, d_write_en, d_addr, d_wdata, d_width,
    output mem_ack, mem_rdata, mem_fault,
    input  i_done, i_rdata, i_fault,
    input  d_done, d_rdata, d_fault,
    input  mem_req, mem_write_en, mem_addr, mem_wdata, mem_width
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one variable-latency memory between fetch (I) and load/store (D)
module mem_port_arbiter #(
  parameter int XLEN         = 32,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic               clock,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GRANT_I = 2'd1;
  localparam logic [1:0] GRANT_D = 2'd2;
  localparam logic [1:0] RESP    = 2'd3;

  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  logic [1:0]      state_q, state_d;
  logic [SW-1:0]   streak_q, streak_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            gnt_i_q, gnt_i_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [1:0]      width_q, width_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            fault_q, fault_d;

  logic pick_i;

  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    timer_d  = timer_q;
    gnt_i_d  = gnt_i_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    width_d  = width_q;
    rdata_d  = rdata_q;
    fault_d  = fault_q;
    // D is the older instruction, so it wins unless I has waited out a full streak
    pick_i   = bus.i_req && (!bus.d_req || streak_q == STREAK_MAX);

    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (pick_i) begin
          state_d  = GRANT_I;
          gnt_i_d  = 1'b1;
          we_d     = 1'b0;
          addr_d   = bus.i_addr;
          wdata_d  = '0;
          width_d  = 2'b10;
          streak_d = '0;
        end else if (bus.d_req) begin
          state_d  = GRANT_D;
          gnt_i_d  = 1'b0;
          we_d     = bus.d_write_en;
          addr_d   = bus.d_addr;
          wdata_d  = bus.d_wdata;
          width_d  = bus.d_width;
          if (!bus.i_req) begin
            streak_d = '0;
          end else if (streak_q != STREAK_MAX) begin
            streak_d = streak_q + SW'(1);
          end
        end
      end
      GRANT_I, GRANT_D: begin
        timer_d = timer_q + TW'(1);
        // An ack landing in the timeout cycle still counts as a normal completion
        if (bus.mem_ack) begin
          state_d = RESP;
          rdata_d = we_q ? '0 : bus.mem_rdata;
          fault_d = bus.mem_fault;
        end else if (timer_q == TIMER_LAST) begin
          state_d = RESP;
          rdata_d = '0;
          fault_d = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      streak_q <= '0;
      timer_q  <= '0;
      gnt_i_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      width_q  <= 2'b00;
      rdata_q  <= '0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      timer_q  <= timer_d;
      gnt_i_q  <= gnt_i_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      width_q  <= width_d;
      rdata_q  <= rdata_d;
      fault_q  <= fault_d;
    end
  end

  logic resp;
  assign resp = (state_q == RESP);

  assign bus.i_done       = resp && gnt_i_q;
  assign bus.d_done       = resp && !gnt_i_q;
  assign bus.i_rdata      = bus.i_done ? rdata_q : '0;
  assign bus.i_fault      = bus.i_done && fault_q;
  assign bus.d_rdata      = bus.d_done ? rdata_q : '0;
  assign bus.d_fault      = bus.d_done && fault_q;

  // mem_req is purely a function of the state flop so an async reset drops it at once
  assign bus.mem_req      = (state_q == GRANT_I) || (state_q == GRANT_D);
  assign bus.mem_write_en = we_q;
  assign bus.mem_addr     = addr_q;
  assign bus.mem_wdata    = wdata_q;
  assign bus.mem_width    = width_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed vector bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_fail;

  mem_port_arbiter_if #(.XLEN(32)) bus ();

  mem_port_arbiter #(.XLEN(32), .MAX_D_STREAK(4), .TIMEOUT(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        i_req;
    logic        d_req;
    logic        d_we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  width;
    int          k;
    logic [31:0] mrdata;
    logic        mfault;
    logic        exp_i;
    logic [31:0] exp_rdata;
    logic        exp_fault;
    logic [1:0]  exp_width;
    int          exp_lat;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int    done_cyc;
    int    mreq_cnt;
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clock);
    bus.i_req      = v.i_req;
    bus.i_addr     = v.i_req ? v.addr : 32'h0;
    bus.d_req      = v.d_req;
    bus.d_write_en = v.d_we;
    bus.d_addr     = v.d_req ? v.addr : 32'h0;
    bus.d_wdata    = v.d_req ? v.wdata : 32'hFFFF_0000;
    bus.d_width    = v.width;
    done_cyc = 0;
    mreq_cnt = 0;
    for (int c = 1; c <= 30 && done_cyc == 0; c++) begin
      @(negedge clock);
      bus.mem_ack   = (v.k != 0) && (c == v.k);
      bus.mem_rdata = bus.mem_ack ? v.mrdata : 32'hBAD0_BAD0;
      bus.mem_fault = bus.mem_ack ? v.mfault : 1'b0;
      if (c == 1) begin
        chk({tag, "_mem_req"}, 32'(bus.mem_req), 32'd1);
        chk({tag, "_mem_we"}, 32'(bus.mem_write_en), v.exp_i ? 32'd0 : 32'(v.d_we));
        chk({tag, "_mem_addr"}, bus.mem_addr, v.addr);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, v.exp_i ? 32'h0 : v.wdata);
        chk({tag, "_mem_width"}, 32'(bus.mem_width), 32'(v.exp_width));
      end
      if (bus.mem_req) mreq_cnt++;
      if (bus.i_done || bus.d_done) begin
        done_cyc = c;
        chk({tag, "_i_done"}, 32'(bus.i_done), 32'(v.exp_i));
        chk({tag, "_d_done"}, 32'(bus.d_done), 32'(!v.exp_i));
        chk({tag, "_rdata"}, v.exp_i ? bus.i_rdata : bus.d_rdata, v.exp_rdata);
        chk({tag, "_fault"}, 32'(v.exp_i ? bus.i_fault : bus.d_fault), 32'(v.exp_fault));
        chk({tag, "_other_rdata"}, v.exp_i ? bus.d_rdata : bus.i_rdata, 32'h0);
        chk({tag, "_other_fault"}, 32'(v.exp_i ? bus.d_fault : bus.i_fault), 32'd0);
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
      end
    end
    bus.mem_ack = 1'b0;
    chk({tag, "_latency"}, 32'(done_cyc), 32'(v.exp_lat));
    chk({tag, "_mem_req_cycles"}, 32'(mreq_cnt), 32'(v.exp_lat - 1));
  endtask

  logic order_d[10];

  initial begin
    logic found;
    logic got_d;
    n_checks = 0;
    n_fail   = 0;
    // i_req d_req we addr wdata width k mrdata mfault | exp_i exp_rdata exp_fault exp_width exp_lat
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h100, 32'h0,    2'b00, 3, 32'hDEADBEEF, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 2'b10, 4};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 32'h200, 32'h55AA, 2'b00, 1, 32'h12345678, 1'b0, 1'b0, 32'h0,        1'b0, 2'b00, 2};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h300, 32'h0,    2'b01, 2, 32'hCAFEF00D, 1'b0, 1'b0, 32'hCAFEF00D, 1'b0, 2'b01, 3};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 32'h400, 32'h0,    2'b10, 0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 2'b10, 9};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 32'h104, 32'h0,    2'b00, 1, 32'hAAAA5555, 1'b1, 1'b1, 32'hAAAA5555, 1'b1, 2'b10, 2};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 32'h500, 32'h77,   2'b01, 2, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h0,        1'b1, 2'b01, 3};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 32'h600, 32'h0,    2'b10, 8, 32'h0BADC0DE, 1'b0, 1'b0, 32'h0BADC0DE, 1'b0, 2'b10, 9};
    order_d = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    bus.i_req = 1'b0; bus.i_addr = 32'h0;
    bus.d_req = 1'b0; bus.d_write_en = 1'b0; bus.d_addr = 32'h0;
    bus.d_wdata = 32'h0; bus.d_width = 2'b00;
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0; bus.mem_fault = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_done", 32'({bus.i_done, bus.d_done}), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_mem_width", 32'({bus.mem_write_en, bus.mem_width}), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Both ports held continuously with single-cycle memory
    @(negedge clock);
    bus.i_req = 1'b1; bus.i_addr = 32'h1000;
    bus.d_req = 1'b1; bus.d_addr = 32'h2000; bus.d_write_en = 1'b0; bus.d_width = 2'b10;
    for (int g = 0; g < 10; g++) begin
      found = 1'b0;
      for (int c = 0; c < 6 && !found; c++) begin
        @(negedge clock);
        if (bus.mem_req) found = 1'b1;
      end
      chk($sformatf("arb%0d_grant_seen", g), 32'(found), 32'd1);
      got_d = (bus.mem_addr == 32'h2000);
      chk($sformatf("arb%0d_port_is_d", g), 32'(got_d), 32'(order_d[g]));
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'(g) + 32'h10;
      @(negedge clock);
      bus.mem_ack = 1'b0;
      chk($sformatf("arb%0d_done", g), 32'({bus.i_done, bus.d_done}), order_d[g] ? 32'd1 : 32'd2);
      chk($sformatf("arb%0d_rdata", g), order_d[g] ? bus.d_rdata : bus.i_rdata, 32'(g) + 32'h10);
    end
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    repeat (3) @(negedge clock);

    // Async reset in the middle of a D grant
    bus.d_req = 1'b1; bus.d_addr = 32'h700; bus.d_write_en = 1'b0; bus.d_width = 2'b10;
    @(negedge clock);
    chk("rst_mid_pre_mem_req", 32'(bus.mem_req), 32'd1);
    chk("rst_mid_pre_addr", bus.mem_addr, 32'h700);
    #2;
    reset = 1'b1;
    bus.i_req = 1'b1; bus.i_addr = 32'h800;
    #1;
    chk("rst_mid_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mid_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_mid_width", 32'(bus.mem_width), 32'd0);
    chk("rst_mid_done", 32'({bus.i_done, bus.d_done}), 32'd0);
    @(negedge clock);
    chk("rst_mid_hold_done", 32'({bus.i_done, bus.d_done, bus.mem_req}), 32'd0);
    reset = 1'b0;
    bus.d_req = 1'b0;
    @(negedge clock);
    chk("rst_after_mem_req", 32'(bus.mem_req), 32'd1);
    chk("rst_after_addr", bus.mem_addr, 32'h800);
    chk("rst_after_width", 32'(bus.mem_width), 32'd2);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h13579BDF; bus.mem_fault = 1'b0;
    @(negedge clock);
    bus.mem_ack = 1'b0;
    chk("rst_after_done", 32'({bus.i_done, bus.d_done}), 32'd2);
    chk("rst_after_rdata", bus.i_rdata, 32'h13579BDF);
    bus.i_req = 1'b0;
    repeat (2) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
